// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for a 12-instruction MIPS-like core
//   (add/sub/and/or/addi/andi/ori/lw/sw/beq/bne/j).  It walks each
//   instruction through IF/ID/EX/MEM/WB over one shared memory port with a
//   ready handshake.  It drives the datapath strobes and mux selects state by
//   state, and it reuses the single-cycle encodings for Aluc, Pcsrc, Regrt,
//   Se, Aluqb and Reg2reg.
//
// Parameters
//   CNT_W    : width of the retired-instruction counter Icount
//   WAIT_MAX : wait cycles allowed per memory request before trapping
//              (0 disables the timeout)
//
// Ports
//   Clk, Reset            : clock (rising edge), synchronous active-high reset
//   Op, Func              : IR[31:26] / IR[5:0], valid from ID onward
//   Z                     : ALU zero flag (combinational, used in EX)
//   Memrdy                : memory completes the current request this cycle
//   Memrd, Memwr, Iord    : memory read/write request, address select
//   Irwr, Pcwr, Pcsrc     : IR load, PC write enable, PC source select
//   Regrt, Se, Aluqb, Aluc: datapath decode selects
//   Wreg, Reg2reg         : register write enable, write-back source select
//   State                 : current state encoding (debug)
//   Retire, Icount        : completion pulse and retired-instruction count
//   Trap                  : sticky illegal-instruction / memory-timeout flag
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Z,
  input  logic             Memrdy,
  output logic             Memrd,
  output logic             Memwr,
  output logic             Iord,
  output logic             Irwr,
  output logic             Pcwr,
  output logic [1:0]       Pcsrc,
  output logic             Regrt,
  output logic             Se,
  output logic             Aluqb,
  output logic [1:0]       Aluc,
  output logic             Wreg,
  output logic             Reg2reg,
  output logic [2:0]       State,
  output logic             Retire,
  output logic [CNT_W-1:0] Icount,
  output logic             Trap
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b111
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;

  // Last wait-count value before the timeout fires; unused when WAIT_MAX==0.
  localparam logic [31:0] WAIT_LAST = (WAIT_MAX == 0) ? 32'd0 : 32'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [31:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0] icount_q, icount_d;

  // Instruction decode (IR is stable from ID until the instruction retires)
  logic is_r, r_add, r_sub, r_and, r_or;
  logic is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j;
  logic is_imm, legal;
  logic [1:0] dec_aluc;
  logic       dec_aluqb, dec_se;

  assign is_r    = (Op == OP_R);
  assign r_add   = is_r && (Func == F_ADD);
  assign r_sub   = is_r && (Func == F_SUB);
  assign r_and   = is_r && (Func == F_AND);
  assign r_or    = is_r && (Func == F_OR);
  assign is_addi = (Op == OP_ADDI);
  assign is_andi = (Op == OP_ANDI);
  assign is_ori  = (Op == OP_ORI);
  assign is_lw   = (Op == OP_LW);
  assign is_sw   = (Op == OP_SW);
  assign is_beq  = (Op == OP_BEQ);
  assign is_bne  = (Op == OP_BNE);
  assign is_j    = (Op == OP_J);
  assign is_imm  = is_addi | is_andi | is_ori;
  assign legal   = r_add | r_sub | r_and | r_or | is_imm | is_lw | is_sw |
                   is_beq | is_bne | is_j;

  // Branches compare by subtraction; loads/stores compute addresses by add.
  always_comb begin
    dec_aluc = 2'b00;
    if (r_sub | is_beq | is_bne) dec_aluc = 2'b01;
    else if (r_and | is_andi)    dec_aluc = 2'b10;
    else if (r_or | is_ori)      dec_aluc = 2'b11;
  end
  assign dec_aluqb = r_add | r_sub | r_and | r_or | is_beq | is_bne;
  assign dec_se    = is_addi | is_lw | is_sw | is_beq | is_bne;

  // A request that has waited WAIT_MAX cycles with no Memrdy gives up.
  logic wait_expired;
  assign wait_expired = (WAIT_MAX != 0) && (wcnt_q == WAIT_LAST);

  // Ungated outputs, decoded from state (and Memrdy/Z where handshaked)
  logic memrd_c, memwr_c, irwr_c, pcwr_c, wreg_c, retire_c;

  always_comb begin
    memrd_c  = 1'b0;
    memwr_c  = 1'b0;
    irwr_c   = 1'b0;
    pcwr_c   = 1'b0;
    wreg_c   = 1'b0;
    retire_c = 1'b0;
    Iord     = 1'b0;
    Pcsrc    = 2'b00;
    Regrt    = 1'b0;
    Se       = 1'b0;
    Aluqb    = 1'b0;
    Aluc     = 2'b00;
    Reg2reg  = 1'b0;
    case (state_q)
      S_IF: begin
        memrd_c = 1'b1;
        if (Memrdy) begin
          irwr_c = 1'b1;
          pcwr_c = 1'b1;
        end
      end
      S_ID: begin
        if (is_j) begin
          pcwr_c   = 1'b1;
          Pcsrc    = 2'b11;
          retire_c = 1'b1;
        end
      end
      S_EX: begin
        Aluc  = dec_aluc;
        Aluqb = dec_aluqb;
        Se    = dec_se;
        if (is_beq | is_bne) begin
          pcwr_c   = is_beq ? Z : ~Z;
          Pcsrc    = 2'b10;
          retire_c = 1'b1;
        end
      end
      S_MEM: begin
        Iord    = 1'b1;
        memrd_c = is_lw;
        memwr_c = is_sw;
        if (Memrdy && is_sw) retire_c = 1'b1;
      end
      S_WB: begin
        wreg_c   = 1'b1;
        Regrt    = is_imm | is_lw;
        Reg2reg  = ~is_lw;
        retire_c = 1'b1;
      end
      default: ;
    endcase
  end

  // A reset cycle must never leak a partial write, fetch or retire.
  assign Memrd  = memrd_c  & ~Reset;
  assign Memwr  = memwr_c  & ~Reset;
  assign Irwr   = irwr_c   & ~Reset;
  assign Pcwr   = pcwr_c   & ~Reset;
  assign Wreg   = wreg_c   & ~Reset;
  assign Retire = retire_c & ~Reset;

  // Next state; the wait counter restarts whenever a request is not pending.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = 32'd0;
    icount_d = icount_q + CNT_W'(Retire);
    case (state_q)
      S_IF: begin
        if (Memrdy)            state_d = S_ID;
        else if (wait_expired) state_d = S_TRAP;
        else                   wcnt_d  = wcnt_q + 32'd1;
      end
      S_ID: begin
        if (!legal)    state_d = S_TRAP;
        else if (is_j) state_d = S_IF;
        else           state_d = S_EX;
      end
      S_EX: begin
        if (is_beq | is_bne)    state_d = S_IF;
        else if (is_lw | is_sw) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM: begin
        if (Memrdy)            state_d = is_lw ? S_WB : S_IF;
        else if (wait_expired) state_d = S_TRAP;
        else                   wcnt_d  = wcnt_q + 32'd1;
      end
      S_WB:    state_d = S_IF;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IF;
      wcnt_q   <= 32'd0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      icount_q <= icount_d;
    end
  end

  assign State  = state_q;
  assign Icount = icount_q;
  assign Trap   = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam int WM = 4;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EX = 3'b010,
                         ST_MEM = 3'b011, ST_WB = 3'b100, ST_TRAP = 3'b111;
  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_ILL = 5;

  logic          Clk = 1'b0;
  logic          Reset, Z, Memrdy;
  logic [5:0]    Op, Func;
  logic          Memrd, Memwr, Iord, Irwr, Pcwr, Regrt, Se, Aluqb, Wreg, Reg2reg;
  logic [1:0]    Pcsrc, Aluc;
  logic [2:0]    State;
  logic          Retire, Trap;
  logic [CW-1:0] Icount;

  always #5 Clk = ~Clk;

  multicycle_ctrl #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Func(Func), .Z(Z), .Memrdy(Memrdy),
    .Memrd(Memrd), .Memwr(Memwr), .Iord(Iord), .Irwr(Irwr), .Pcwr(Pcwr),
    .Pcsrc(Pcsrc), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc),
    .Wreg(Wreg), .Reg2reg(Reg2reg), .State(State), .Retire(Retire),
    .Icount(Icount), .Trap(Trap)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          memrd, memwr, iord, irwr, pcwr;
    logic [1:0]    pcsrc;
    logic          regrt, se, aluqb;
    logic [1:0]    aluc;
    logic          wreg, reg2reg, retire, trap;
    logic [CW-1:0] icount;
  } obs_t;

  typedef struct {
    string      name;
    logic [5:0] op, func;
    logic       z;
    int         cls, wif, wmem;
    logic [1:0] aluc;
    logic       aluqb, se, regrt, reg2reg, taken;
  } vec_t;

  obs_t          act;
  obs_t          exp_q[$];
  string         tag_q[$];
  obs_t          chk_e;
  string         chk_t;
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] icnt_m;
  vec_t          tbl[18];

  always_comb act = {State, Memrd, Memwr, Iord, Irwr, Pcwr, Pcsrc, Regrt, Se,
                     Aluqb, Aluc, Wreg, Reg2reg, Retire, Trap, Icount};

  // Scoreboard: each driven cycle pushes its expectation, popped mid-cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      chk_e = exp_q.pop_front();
      chk_t = tag_q.pop_front();
      checks++;
      if (act !== chk_e) begin
        errors++;
        $display("FAIL %s: got %b required %b (st,rd,wr,iord,irwr,pcwr,pcsrc,rt,se,qb,aluc,wreg,r2r,ret,trap,icnt)",
                 chk_t, act, chk_e);
      end
    end
  end

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e;
    e        = '0;
    e.st     = st;
    e.trap   = (st == ST_TRAP);
    e.icount = icnt_m;
    return e;
  endfunction

  task automatic step(input logic rst, input logic rdy, input obs_t e, input string t);
    Reset  = rst;
    Memrdy = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge Clk);
    #1;
    if (e.retire) icnt_m = icnt_m + 1'b1;
    if (rst) icnt_m = '0;
  endtask

  task automatic run_instr(input vec_t v);
    obs_t e;
    logic trapped;
    trapped = 1'b0;
    Op = v.op; Func = v.func; Z = v.z;
    for (int w = 0; w < v.wif && !trapped; w++) begin
      e = mk(ST_IF); e.memrd = 1'b1;
      step(1'b0, 1'b0, e, {v.name, "/if_wait"});
      if (w == WM - 1) trapped = 1'b1;
    end
    if (!trapped) begin
      e = mk(ST_IF); e.memrd = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
      step(1'b0, 1'b1, e, {v.name, "/if"});
      e = mk(ST_ID);
      if (v.cls == C_J) begin
        e.pcwr = 1'b1; e.pcsrc = 2'b11; e.retire = 1'b1;
      end
      step(1'b0, 1'b1, e, {v.name, "/id"});
      if (v.cls == C_ILL) trapped = 1'b1;
      else if (v.cls != C_J) begin
        e = mk(ST_EX); e.aluc = v.aluc; e.aluqb = v.aluqb; e.se = v.se;
        if (v.cls == C_BR) begin
          e.pcwr = v.taken; e.pcsrc = 2'b10; e.retire = 1'b1;
        end
        step(1'b0, 1'b1, e, {v.name, "/ex"});
        if (v.cls == C_LW || v.cls == C_SW) begin
          for (int w = 0; w < v.wmem && !trapped; w++) begin
            e = mk(ST_MEM); e.iord = 1'b1;
            e.memrd = (v.cls == C_LW); e.memwr = (v.cls == C_SW);
            step(1'b0, 1'b0, e, {v.name, "/mem_wait"});
            if (w == WM - 1) trapped = 1'b1;
          end
          if (!trapped) begin
            e = mk(ST_MEM); e.iord = 1'b1;
            e.memrd = (v.cls == C_LW); e.memwr = (v.cls == C_SW);
            e.retire = (v.cls == C_SW);
            step(1'b0, 1'b1, e, {v.name, "/mem"});
          end
        end
        if (!trapped && (v.cls == C_R || v.cls == C_LW)) begin
          e = mk(ST_WB); e.wreg = 1'b1; e.regrt = v.regrt; e.reg2reg = v.reg2reg;
          e.retire = 1'b1;
          step(1'b0, 1'b1, e, {v.name, "/wb"});
        end
      end
    end
    if (trapped) begin
      for (int k = 0; k < 3; k++) begin
        e = mk(ST_TRAP);
        step(1'b0, k[0], e, {v.name, "/trap_hold"});
      end
      e = mk(ST_TRAP);
      step(1'b1, 1'b1, e, {v.name, "/trap_reset"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    vec_t ori_v;
    //          name        op     func   z     cls    wif wmem aluc  qb    se    rt    r2r   taken
    tbl[0]  = '{"add",     6'h00, 6'h20, 1'b0, C_R,   0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{"sub",     6'h00, 6'h22, 1'b0, C_R,   0, 0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{"and",     6'h00, 6'h24, 1'b1, C_R,   2, 0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{"or",      6'h00, 6'h25, 1'b0, C_R,   0, 0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{"addi",    6'h08, 6'h3F, 1'b0, C_R,   0, 0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{"andi",    6'h0C, 6'h20, 1'b0, C_R,   1, 0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{"ori_w3",  6'h0D, 6'h00, 1'b0, C_R,   3, 0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{"lw_w3",   6'h23, 6'h00, 1'b0, C_LW,  0, 3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{"sw_w1",   6'h2B, 6'h00, 1'b0, C_SW,  0, 1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{"beq_z1",  6'h04, 6'h00, 1'b1, C_BR,  0, 0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{"beq_z0",  6'h04, 6'h00, 1'b0, C_BR,  0, 0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{"bne_z1",  6'h05, 6'h00, 1'b1, C_BR,  0, 0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{"bne_z0",  6'h05, 6'h00, 1'b0, C_BR,  0, 0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{"j",       6'h02, 6'h00, 1'b0, C_J,   0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{"ill_op",  6'h3F, 6'h20, 1'b0, C_ILL, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{"ill_fn",  6'h00, 6'h00, 1'b0, C_ILL, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{"if_tmo",  6'h00, 6'h20, 1'b0, C_R,   4, 0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{"lw_tmo",  6'h23, 6'h00, 1'b0, C_LW,  0, 4, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    Reset = 1'b1; Memrdy = 1'b0; Z = 1'b0; Op = 6'h00; Func = 6'h20;
    icnt_m = '0;
    @(posedge Clk);
    #1;
    step(1'b1, 1'b1, mk(ST_IF), "reset");

    for (int i = 0; i < 18; i++) run_instr(tbl[i]);

    // Reset asserted in the MEM cycle of a store: no Memwr, no retire, IF next.
    Op = 6'h2B; Func = 6'h00; Z = 1'b0;
    e = mk(ST_IF); e.memrd = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    step(1'b0, 1'b1, e, "swrst/if");
    e = mk(ST_ID);
    step(1'b0, 1'b0, e, "swrst/id");
    e = mk(ST_EX); e.se = 1'b1;
    step(1'b0, 1'b0, e, "swrst/ex");
    e = mk(ST_MEM); e.iord = 1'b1;
    step(1'b1, 1'b1, e, "swrst/mem_reset");
    run_instr(tbl[0]);

    // Counter wrap: 16 ori after reset take Icount 0..15 and back to 0.
    step(1'b1, 1'b0, mk(ST_IF), "wrap/reset");
    ori_v = tbl[6];
    ori_v.wif = 0;
    ori_v.name = "ori_wrap";
    for (int n = 0; n < 16; n++) run_instr(ori_v);
    checks++;
    if (Icount !== {CW{1'b0}}) begin
      errors++;
      $display("FAIL icount_wrap: got %0d required 0", Icount);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
